// File: rtl/result_drain_buffer_pkg.sv
// Shared defaults and helpers for the result drain path; defaults follow the
// ARRAYWIDTH / DATASIZE / RESULT_FIFO_DEPTH config macros when they are defined.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif

`ifndef DATASIZE
`define DATASIZE 8
`endif

`ifndef RESULT_FIFO_DEPTH
`define RESULT_FIFO_DEPTH 8
`endif

package result_drain_buffer_pkg;

   localparam int RDB_ARRAYWIDTH = `ARRAYWIDTH;
   localparam int RDB_DATASIZE   = `DATASIZE;
   localparam int RDB_DEPTH      = `RESULT_FIFO_DEPTH;

   // Column 0 leaves the array first, so it waits longest to line up with the last column.
   function automatic int col_delay(input int array_width, input int col);
      return array_width - 1 - col;
   endfunction

endpackage

// File: rtl/result_deskew_register.sv
// Fixed-length shift register, DELAY cycles, no backpressure (shifts every cycle).
// clr zeroes every stage synchronously; DELAY=0 is a plain wire.
module result_deskew_register #(
   parameter int DELAY = 1,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DELAY == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, clk, rst, clr};
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DELAY];
         logic [WIDTH-1:0] stage_d [DELAY];

         always_comb begin
            for (int k = 0; k < DELAY; k++) begin
               stage_d[k] = '0;
            end
            if (!clr) begin
               stage_d[0] = din;
               for (int k = 1; k < DELAY; k++) begin
                  stage_d[k] = stage_q[k-1];
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < DELAY; k++) begin
                  stage_q[k] <= '0;
               end
            end else begin
               for (int k = 0; k < DELAY; k++) begin
                  stage_q[k] <= stage_d[k];
               end
            end
         end

         assign dout = stage_q[DELAY-1];
      end
   endgenerate

endmodule

// File: rtl/result_drain_buffer.sv
// Deskews the array's bottom-edge result stream into rows and queues them; in_valid at t gives out_valid at t+ARRAYWIDTH.
// No input backpressure: a row aligning while full with no same-cycle pop is dropped and sets sticky overflow.
module result_drain_buffer
   import result_drain_buffer_pkg::*;
#(
   parameter int ARRAYWIDTH = RDB_ARRAYWIDTH,
   parameter int DATASIZE   = RDB_DATASIZE,
   parameter int DEPTH      = RDB_DEPTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           in_valid,
   input  logic [ARRAYWIDTH*DATASIZE-1:0] in_result,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ARRAYWIDTH*DATASIZE-1:0] out_row,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           full,
   output logic                           overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = ARRAYWIDTH * DATASIZE;

   logic [RW-1:0] row_dat;
   logic          row_valid;

   genvar gi;
   generate
      for (gi = 0; gi < ARRAYWIDTH; gi++) begin : g_col
         result_deskew_register #(
            .DELAY (col_delay(ARRAYWIDTH, gi)),
            .WIDTH (DATASIZE)
         ) u_col (
            .clk  (clk),
            .rst  (rst),
            .clr  (flush),
            .din  (in_result[gi*DATASIZE +: DATASIZE]),
            .dout (row_dat[gi*DATASIZE +: DATASIZE])
         );
      end
   endgenerate

   result_deskew_register #(
      .DELAY (ARRAYWIDTH - 1),
      .WIDTH (1)
   ) u_vld (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush),
      .din  (in_valid),
      .dout (row_valid)
   );

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [RW-1:0] mem_q [DEPTH];
   logic          pop, push, accept;

   // A pop in the same cycle frees a slot, so a full FIFO can still take the aligning row.
   always_comb begin
      pop        = (count_q != '0) && out_ready && !flush;
      accept     = (count_q != CW'(DEPTH)) || ((count_q != '0) && out_ready);
      push       = row_valid && accept && !flush;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
         if (row_valid && !accept) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= row_dat;
      end
   end

   assign out_valid = (count_q != '0);
   assign out_row   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign count     = count_q;
   assign full      = (count_q == CW'(DEPTH));
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_drain_buffer.sv
// Directed plus randomized bench for result_drain_buffer, checked against a
// row-queue reference model that tracks when each issued row lines up.
module tb_result_drain_buffer;

   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int DEP  = 8;
   localparam int RW   = AW * DW;
   localparam int MAXC = 4096;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic [RW-1:0] in_result;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] out_row;
   logic [3:0]    count;
   logic          full;
   logic          overflow;

   always #5 clk = ~clk;

   result_drain_buffer #(
      .ARRAYWIDTH (AW),
      .DATASIZE   (DW),
      .DEPTH      (DEP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_result (in_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .count     (count),
      .full      (full),
      .overflow  (overflow)
   );

   int            ntests = 0;
   int            nfail  = 0;
   int            cyc    = 0;
   bit            fill_ff;
   logic [RW-1:0] model_q [$];
   bit            model_ovf;
   bit            iss_drv  [MAXC];
   bit            iss_live [MAXC];
   logic [RW-1:0] iss_row  [MAXC];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      ntests++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] mk_row(input int r);
      logic [RW-1:0] v;
      for (int i = 0; i < AW; i++) begin
         v[i*DW +: DW] = 8'(r * 16 + i);
      end
      return v;
   endfunction

   task automatic check_model();
      logic [RW-1:0] exp_row;
      exp_row = '0;
      if (model_q.size() != 0) exp_row = model_q[0];
      chk("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      chk("out_row",   64'(out_row),   64'(exp_row));
      chk("count",     64'(count),     64'(model_q.size()));
      chk("full",      64'(full),      64'(model_q.size() == DEP));
      chk("overflow",  64'(overflow),  64'(model_ovf));
   endtask

   // One clock cycle: check state, drive skewed inputs, advance the model.
   task automatic tick(input bit v, input logic [RW-1:0] row, input bit rdy, input bit fl);
      bit            aligned, popm, acc;
      logic [RW-1:0] drv;
      check_model();
      iss_drv[cyc]  = v;
      iss_live[cyc] = v;
      iss_row[cyc]  = row;
      for (int i = 0; i < AW; i++) begin
         if (cyc >= i && iss_drv[cyc-i]) drv[i*DW +: DW] = iss_row[cyc-i][i*DW +: DW];
         else if (fill_ff)               drv[i*DW +: DW] = 8'hFF;
         else                            drv[i*DW +: DW] = 8'($urandom);
      end
      in_result = drv;
      in_valid  = v;
      out_ready = rdy;
      flush     = fl;
      if (fl) begin
         model_q.delete();
         model_ovf = 1'b0;
         for (int k = 0; k < AW; k++) if (cyc >= k) iss_live[cyc-k] = 1'b0;
      end else begin
         aligned = (cyc >= AW - 1) && iss_live[cyc-(AW-1)];
         popm    = (model_q.size() != 0) && rdy;
         acc     = (model_q.size() < DEP) || popm;
         if (popm) void'(model_q.pop_front());
         if (aligned) begin
            if (acc) model_q.push_back(iss_row[cyc-(AW-1)]);
            else     model_ovf = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Reset asserted mid-cycle, checked asynchronously, released on the falling edge.
   task automatic do_reset();
      #2;
      rst       = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_count",     64'(count),     64'(0));
      chk("rst_full",      64'(full),      64'(0));
      chk("rst_overflow",  64'(overflow),  64'(0));
      chk("rst_out_row",   64'(out_row),   64'(0));
      model_q.delete();
      model_ovf = 1'b0;
      for (int k = 0; k <= cyc; k++) iss_live[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      rst = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_result = '0;
      fill_ff   = 1'b1;
      model_ovf = 1'b0;
      #12;
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_out_row",   64'(out_row),   64'(0));
      chk("reset_count",     64'(count),     64'(0));
      chk("reset_full",      64'(full),      64'(0));
      chk("reset_overflow",  64'(overflow),  64'(0));
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;

      // single row issued at cycle 10, FF filler elsewhere
      while (cyc < 10) tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b1, 32'h13121110, 1'b0, 1'b0);
      while (cyc < 13) tick(1'b0, '0, 1'b0, 1'b0);
      chk("single_not_yet_valid", 64'(out_valid), 64'(0));
      tick(1'b0, '0, 1'b0, 1'b0);
      chk("single_valid_c14", 64'(out_valid), 64'(1));
      chk("single_row_c14",   64'(out_row),   64'h13121110);
      chk("single_count_c14", 64'(count),     64'(1));
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("single_count_c15", 64'(count),   64'(0));
      chk("single_row_c15",   64'(out_row), 64'(0));

      // burst fill, overflow, in-order drain
      fill_ff = 1'b0;
      for (int r = 0; r < 8; r++) tick(1'b1, mk_row(r), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b0, 1'b0);
      chk("burst_full",  64'(full),  64'(1));
      chk("burst_count", 64'(count), 64'(8));
      tick(1'b1, mk_row(8), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b0, 1'b0);
      chk("ovf_flag",  64'(overflow), 64'(1));
      chk("ovf_count", 64'(count),    64'(8));
      chk("ovf_head",  64'(out_row),  64'(mk_row(0)));
      for (int r = 0; r < 8; r++) begin
         chk("burst_order", 64'(out_row), 64'(mk_row(r)));
         tick(1'b0, '0, 1'b1, 1'b0);
      end
      chk("ovf_held",    64'(overflow), 64'(1));
      chk("drain_empty", 64'(count),    64'(0));
      tick(1'b0, '0, 1'b0, 1'b1);
      chk("ovf_flush_clear", 64'(overflow), 64'(0));

      // full with a pop in the cycle a ninth row lines up
      for (int r = 0; r < 8; r++) tick(1'b1, mk_row(16 + r), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b0, 1'b0);
      chk("fullpop_full", 64'(full), 64'(1));
      tick(1'b1, mk_row(40), 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("fullpop_count", 64'(count),    64'(8));
      chk("fullpop_ovf",   64'(overflow), 64'(0));
      for (int k = 0; k < 7; k++) tick(1'b0, '0, 1'b1, 1'b0);
      chk("fullpop_last_row", 64'(out_row), 64'(mk_row(40)));
      chk("fullpop_last_cnt", 64'(count),   64'(1));
      tick(1'b0, '0, 1'b1, 1'b0);

      // steady stream of 20 rows, pointers wrap
      for (int k = 0; k < 40; k++) tick(k % 2 == 0, RW'($urandom), (k % 2 == 1) && (k >= 6), 1'b0);
      for (int k = 0; k < 10; k++) tick(1'b0, '0, 1'b1, 1'b0);
      chk("wrap_empty", 64'(count),    64'(0));
      chk("wrap_noovf", 64'(overflow), 64'(0));

      // flush with 3 queued and 1 in flight
      for (int r = 0; r < 3; r++) tick(1'b1, RW'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b1, RW'($urandom), 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b1);
      chk("flush_count", 64'(count),     64'(0));
      chk("flush_valid", 64'(out_valid), 64'(0));
      for (int k = 0; k < 6; k++) tick(1'b0, '0, 1'b0, 1'b0);
      chk("flush_no_ghost", 64'(count), 64'(0));

      // same scenario with an asynchronous reset pulse
      for (int r = 0; r < 3; r++) tick(1'b1, RW'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b1, RW'($urandom), 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      do_reset();
      for (int k = 0; k < 6; k++) tick(1'b0, '0, 1'b0, 1'b0);
      chk("rst_no_ghost", 64'(count), 64'(0));

      // randomized traffic with occasional flushes
      for (int k = 0; k < 400; k++) begin
         tick(($urandom % 3) != 0, RW'($urandom), 1'($urandom % 2), ($urandom % 50) == 0);
      end
      for (int k = 0; k < 12; k++) tick(1'b0, '0, 1'b1, 1'b0);
      chk("final_empty", 64'(count), 64'(0));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/result_drain_buffer.md
Name: result_drain_buffer

Overview:
- Output-side counterpart of the weight loading path: captures the skewed result stream leaving the bottom edge of the systolic array and deskews it into aligned rows.
- Column i of a given row arrives i cycles after column 0 of that row.
- Aligned rows are queued in a row FIFO and drained to the host or writeback logic over a valid/ready handshake.

Parameters:
- ARRAYWIDTH, `ARRAYWIDTH (4): number of array columns.
- DATASIZE, `DATASIZE (8): bits per column result.
- DEPTH, 8: row FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO, delay lines and overflow flag.
- in_valid  in  1  column-0 result valid; qualifies the row whose column i arrives i cycles later.
- in_result  in  ARRAYWIDTH*DATASIZE  skewed column results; column i occupies bits [(i+1)*DATASIZE-1 : i*DATASIZE].
- out_valid  out  1  FIFO head row valid.
- out_ready  in  1  consumer accepts the head row.
- out_row  out  ARRAYWIDTH*DATASIZE  aligned head row, same column packing as in_result.
- count  out  $clog2(DEPTH)+1  rows currently queued.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky flag: an aligned row was dropped.

Behaviour:
- Reset (rst low, asynchronous): pointers 0, count 0, all delay-line data and valid bits 0, overflow 0. Outputs read out_valid 0, out_row 0, full 0. FIFO storage is not reset.
- Deskew:
  - Column i passes through ARRAYWIDTH-1-i registers.
  - Column ARRAYWIDTH-1 is unregistered.
  - in_valid passes through ARRAYWIDTH-1 registers, producing row_valid.
  - Column data registers shift every cycle, regardless of valid.
- Write:
  - If in_valid is high at cycle t, the aligned row is present at cycle t+ARRAYWIDTH-1 with row_valid high.
  - It is written at the edge ending that cycle when accepted.
  - Accept condition: !full, or (out_valid && out_ready) in the same cycle.
  - If row_valid is high and the row is not accepted, the row is dropped and overflow is set to 1. overflow clears only on rst or flush.
- Read:
  - out_row = storage[rd_ptr] when count != 0, else all zeros.
  - out_valid = (count != 0).
  - Pop on out_valid && out_ready. out_ready while empty has no effect.
- Latency: from in_valid at t into an empty FIFO, out_valid is high at cycle t+ARRAYWIDTH. There is no bypass path.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, a simultaneous pop frees the slot and the push is accepted.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Back-to-back in_valid on consecutive cycles is legal and yields consecutive rows in order.
- Flush (synchronous):
  - Zeroes pointers, count, valid delay bits and overflow.
  - An in_valid or row_valid in the flush cycle is discarded.
  - Flush takes priority over push and pop.
- Reset mid-stream: all in-flight and queued rows are lost; no partial row is ever emitted afterward.

Decomposition:
- Shared config header (existing config.v): ARRAYWIDTH and DATASIZE macros. Add RESULT_FIFO_DEPTH as the DEPTH default.
- Sub-module result_deskew_register:
  - Parameters DELAY and WIDTH; one instance per column, generate-looped.
  - DELAY=0 degenerates to a wire.
  - Async active-low reset to 0.
- The valid delay line uses the same sub-module with WIDTH=1 and DELAY=ARRAYWIDTH-1.
- FIFO pointer, count and overflow logic stay in the top module.

Test Plan (ARRAYWIDTH=4, DATASIZE=8, DEPTH=8):
- Single row: in_valid at cycle 10; column i driven with value 8'h10+i at cycle 10+i, other cycles 8'hFF -> out_valid rises at cycle 14, out_row = 32'h13121110, count = 1; a pop at cycle 14 gives count 0 and out_row 0 at cycle 15.
- Burst fill: 8 consecutive rows (row r, column i = r*16+i), out_ready=0 -> full=1 and count=8 after the 8th write; rows then drain in order 0..7 with out_ready=1.
- Overflow: FIFO full, out_ready=0, one more row -> row dropped, overflow=1 and held; count stays 8; contents unchanged.
- Full plus simultaneous pop: FIFO full, out_ready=1 in the same cycle a 9th row aligns -> row accepted, overflow stays 0, count stays 8, new row is last out.
- Wrap-around: push/pop 20 rows at steady rate with count oscillating 1..3 -> every row out in order, pointers wrap twice, no loss.
- Flush/reset mid-stream: 3 rows queued and 1 in flight, flush pulse -> count=0, out_valid=0, in-flight row never appears. Repeat with rst low for one cycle mid-edge -> same result asynchronously.
